// File: rtl/fp16_align_frontend.sv
// Purpose: FP16 adder operand front end. Buffers operand pairs, flags NaN/Inf/double-zero,
//          orders by magnitude and aligns the smaller mantissa with guard/round/sticky bits.
// Latency: 2 edges from push to out_valid when idle (FIFO write, then pop into output register).
// Backpressure: output register holds while out_valid & !out_ready; in_ready drops when FIFO full.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid/in_ready     operand-pair handshake; numi1/numi2 binary16 operands
//   out_valid/out_ready   result handshake
//   out_sign_l/_s         signs of larger/smaller-magnitude operand
//   out_exp               biased effective exponent of the larger operand
//   out_man_l             larger mantissa with hidden bit
//   out_man_s             aligned smaller mantissa {hidden, frac, G, R, S}
//   out_expdiff           effective exponent difference
//   out_sub               effective subtraction
//   out_special/_val      special-case result (arithmetic fields don't-care when set)
//   fifo_count            operand FIFO occupancy
//
// Build option: define FP16_FE_FTZ_EN to flush subnormal operands to signed zero.

module fp16_align_frontend #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [15:0]                   numi1,
    input  logic [15:0]                   numi2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sign_l,
    output logic                          out_sign_s,
    output logic [4:0]                    out_exp,
    output logic [10:0]                   out_man_l,
    output logic [13:0]                   out_man_s,
    output logic [4:0]                    out_expdiff,
    output logic                          out_sub,
    output logic                          out_special,
    output logic [15:0]                   out_special_val,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic        sign_l;
        logic        sign_s;
        logic [4:0]  exp;
        logic [10:0] man_l;
        logic [13:0] man_s;
        logic [4:0]  expdiff;
        logic        sub;
        logic        special;
        logic [15:0] special_val;
    } res_t;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_full, fifo_empty;
    logic             push, pop;
    logic [31:0]      head_dat;
    logic             out_valid_q, out_valid_d;
    res_t             res_q, res_d;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign in_ready   = rst_n & ~fifo_full;
    assign push       = in_valid & in_ready;
    // Pop only into a free (or draining) output register; no bypass of an empty FIFO.
    assign pop        = ~fifo_empty & (~out_valid_q | out_ready);
    assign head_dat   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {numi1, numi2};
    end

    // ------------------------------------------------------------------
    // Classification, ordering and alignment of the FIFO head
    // ------------------------------------------------------------------
    logic [15:0] op1, op2, op_l, op_s;
    logic        nan1, nan2, inf1, inf2, zero1, zero2;
    logic        swap;
    logic [4:0]  effexp_l, effexp_s, expdiff;
    logic [10:0] man_l, man_s;
    logic [13:0] ext, shifted, lost_mask, aligned;
    logic        sticky;
    logic        special;
    logic [15:0] special_val;

    always_comb begin
        op1 = head_dat[31:16];
        op2 = head_dat[15:0];
`ifdef FP16_FE_FTZ_EN
        if (op1[14:10] == 5'd0) op1[9:0] = 10'd0;
        if (op2[14:10] == 5'd0) op2[9:0] = 10'd0;
`endif
    end

    assign nan1  = (&op1[14:10]) & (|op1[9:0]);
    assign nan2  = (&op2[14:10]) & (|op2[9:0]);
    assign inf1  = (&op1[14:10]) & ~(|op1[9:0]);
    assign inf2  = (&op2[14:10]) & ~(|op2[9:0]);
    assign zero1 = ~(|op1[14:0]);
    assign zero2 = ~(|op2[14:0]);

    // {exp, frac} orders magnitude directly; ties keep numi1 as the larger.
    assign swap = (op2[14:0] > op1[14:0]);
    assign op_l = swap ? op2 : op1;
    assign op_s = swap ? op1 : op2;

    assign effexp_l = (op_l[14:10] == 5'd0) ? 5'd1 : op_l[14:10];
    assign effexp_s = (op_s[14:10] == 5'd0) ? 5'd1 : op_s[14:10];
    assign man_l    = {|op_l[14:10], op_l[9:0]};
    assign man_s    = {|op_s[14:10], op_s[9:0]};
    // Magnitude ordering guarantees effexp_l >= effexp_s, and the largest
    // possible difference (30 - 1) already fits, so no saturation logic is needed.
    assign expdiff  = effexp_l - effexp_s;

    assign ext       = {man_s, 3'b000};
    assign shifted   = ext >> expdiff;
    assign lost_mask = (14'd1 << expdiff) - 14'd1;
    assign sticky    = |(ext & lost_mask);

    always_comb begin
        if (expdiff >= 5'd14) aligned = {13'd0, |man_s};
        else                  aligned = {shifted[13:1], shifted[0] | sticky};
    end

    always_comb begin
        special     = 1'b0;
        special_val = 16'h0000;
        if (nan1 | nan2) begin
            special     = 1'b1;
            special_val = 16'h7E00;
        end else if (inf1 & inf2 & (op1[15] ^ op2[15])) begin
            special     = 1'b1;
            special_val = 16'h7E00;
        end else if (inf1) begin
            special     = 1'b1;
            special_val = op1;
        end else if (inf2) begin
            special     = 1'b1;
            special_val = op2;
        end else if (zero1 & zero2) begin
            special     = 1'b1;
            special_val = {op1[15] & op2[15], 15'd0};
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_comb begin
        res_d       = res_q;
        out_valid_d = out_valid_q;
        if (pop) begin
            res_d.sign_l      = op_l[15];
            res_d.sign_s      = op_s[15];
            res_d.exp         = effexp_l;
            res_d.man_l       = man_l;
            res_d.man_s       = aligned;
            res_d.expdiff     = expdiff;
            res_d.sub         = op_l[15] ^ op_s[15];
            res_d.special     = special;
            res_d.special_val = special_val;
            out_valid_d       = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_sign_l      = res_q.sign_l;
    assign out_sign_s      = res_q.sign_s;
    assign out_exp         = res_q.exp;
    assign out_man_l       = res_q.man_l;
    assign out_man_s       = res_q.man_s;
    assign out_expdiff     = res_q.expdiff;
    assign out_sub         = res_q.sub;
    assign out_special     = res_q.special;
    assign out_special_val = res_q.special_val;
    assign fifo_count      = count_q;

endmodule

// File: tb/tb_fp16_align_frontend.sv
// Purpose: randomized and directed bench for fp16_align_frontend against a queue-based model.
// Latency: model tracks FIFO contents and output register per cycle.
// Backpressure: random out_ready stalls plus a directed full-FIFO scenario.

module tb_fp16_align_frontend;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] numi1, numi2;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign_l, out_sign_s;
    logic [4:0]  out_exp;
    logic [10:0] out_man_l;
    logic [13:0] out_man_s;
    logic [4:0]  out_expdiff;
    logic        out_sub;
    logic        out_special;
    logic [15:0] out_special_val;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    fp16_align_frontend #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .numi1           (numi1),
        .numi2           (numi2),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sign_l      (out_sign_l),
        .out_sign_s      (out_sign_s),
        .out_exp         (out_exp),
        .out_man_l       (out_man_l),
        .out_man_s       (out_man_s),
        .out_expdiff     (out_expdiff),
        .out_sub         (out_sub),
        .out_special     (out_special),
        .out_special_val (out_special_val),
        .fifo_count      (fifo_count)
    );

    typedef struct {
        bit        special;
        bit [15:0] sval;
        bit        sl, ss, sub;
        int        ex, ml, ms, ed;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    bit [31:0]   mq[$];
    bit          mvalid = 1'b0;
    exp_t        mout;
    bit          last_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference: arithmetic view of ordering/alignment rules.
    function automatic exp_t ref_calc(input bit [15:0] a, input bit [15:0] b);
        exp_t   r;
        int     ea, eb, fa, fb, el, es, fl, fs, effl, effs, d, mnl, mns;
        bit     sa, sb, sl, ss, a_nan, b_nan, a_inf, b_inf;
        longint v, den;
        r  = '{default: 0};
        sa = a[15]; ea = int'(a[14:10]); fa = int'(a[9:0]);
        sb = b[15]; eb = int'(b[14:10]); fb = int'(b[9:0]);
`ifdef FP16_FE_FTZ_EN
        if (ea == 0) fa = 0;
        if (eb == 0) fb = 0;
`endif
        a_nan = (ea == 31) && (fa != 0);
        b_nan = (eb == 31) && (fb != 0);
        a_inf = (ea == 31) && (fa == 0);
        b_inf = (eb == 31) && (fb == 0);
        if (a_nan || b_nan) begin
            r.special = 1; r.sval = 16'h7E00;
        end else if (a_inf && b_inf && (sa != sb)) begin
            r.special = 1; r.sval = 16'h7E00;
        end else if (a_inf) begin
            r.special = 1; r.sval = {sa, 15'h7C00};
        end else if (b_inf) begin
            r.special = 1; r.sval = {sb, 15'h7C00};
        end else if (ea == 0 && fa == 0 && eb == 0 && fb == 0) begin
            r.special = 1; r.sval = {sa & sb, 15'h0000};
        end
        if (ea * 1024 + fa >= eb * 1024 + fb) begin
            sl = sa; el = ea; fl = fa; ss = sb; es = eb; fs = fb;
        end else begin
            sl = sb; el = eb; fl = fb; ss = sa; es = ea; fs = fa;
        end
        effl = (el == 0) ? 1 : el;
        effs = (es == 0) ? 1 : es;
        mnl  = (el == 0 ? 0 : 1024) + fl;
        mns  = (es == 0 ? 0 : 1024) + fs;
        d    = effl - effs;
        v    = longint'(mns) * 8;
        den  = longint'(1) << d;
        r.ms = int'(v / den);
        if ((v % den) != 0) r.ms = r.ms | 1;
        r.ex  = effl;
        r.ml  = mnl;
        r.ed  = (d > 31) ? 31 : d;
        r.sl  = sl;
        r.ss  = ss;
        r.sub = sl ^ ss;
        return r;
    endfunction

    // Drive one cycle from just after a falling edge; check at the next falling edge.
    task automatic step(input bit rst, input bit v, input bit [15:0] a, input bit [15:0] b,
                        input bit rdy);
        bit        exp_rdy, do_push, do_pop;
        bit [31:0] head;
        rst_n = rst; in_valid = v; numi1 = a; numi2 = b; out_ready = rdy;
        #1;
        exp_rdy = rst && (mq.size() < DEPTH);
        check("in_ready", in_ready, exp_rdy);
        last_rdy = in_ready;
        if (!rst) begin
            mq.delete();
            mvalid = 1'b0;
        end else begin
            do_pop  = (mq.size() > 0) && (!mvalid || rdy);
            do_push = v && exp_rdy;
            if (do_pop) begin
                head   = mq.pop_front();
                mout   = ref_calc(head[31:16], head[15:0]);
                mvalid = 1'b1;
            end else if (rdy) begin
                mvalid = 1'b0;
            end
            if (do_push) mq.push_back({a, b});
        end
        @(posedge clk);
        @(negedge clk);
        check("out_valid", out_valid, mvalid);
        check("fifo_count", fifo_count, mq.size());
        if (mvalid) begin
            check("special", out_special, mout.special);
            if (mout.special) begin
                check("special_val", out_special_val, mout.sval);
            end else begin
                check("sign_l", out_sign_l, mout.sl);
                check("sign_s", out_sign_s, mout.ss);
                check("exp", out_exp, mout.ex);
                check("man_l", out_man_l, mout.ml);
                check("man_s", out_man_s, mout.ms);
                check("expdiff", out_expdiff, mout.ed);
                check("sub", out_sub, mout.sub);
            end
        end
    endtask

    task automatic run_one(input bit [15:0] a, input bit [15:0] b);
        step(1'b1, 1'b1, a, b, 1'b1);
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);
    endtask

    function automatic bit [15:0] gen_op();
        bit [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0: r[14:0] = 15'h0000;
            1: r[14:0] = 15'h7C00;
            2: begin r[14:10] = 5'h1F; if (r[9:0] == 10'd0) r[0] = 1'b1; end
            3: r[14:10] = 5'h00;
            4: r[14:10] = 5'($urandom_range(0, 3));
            default: if (r[14:10] == 5'h1F) r[14:10] = 5'h1E;
        endcase
        return r;
    endfunction

    int acc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; numi1 = '0; numi2 = '0;
        @(negedge clk);
        step(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        step(1'b0, 1'b1, 16'h3C00, 16'h3C00, 1'b0);
        check("rst_sign_l", out_sign_l, 0);
        check("rst_exp", out_exp, 0);
        check("rst_man_l", out_man_l, 0);
        check("rst_man_s", out_man_s, 0);
        check("rst_expdiff", out_expdiff, 0);
        check("rst_special", out_special, 0);
        check("rst_special_val", out_special_val, 0);

        // Directed vectors; result visible two edges after the push.
        run_one(16'h3C00, 16'h3E00);
        check("eq_valid", out_valid, 1);
        check("eq_exp", out_exp, 15);
        check("eq_man_l", out_man_l, 11'h600);
        check("eq_man_s", out_man_s, 14'h2000);
        check("eq_expdiff", out_expdiff, 0);
        check("eq_sub", out_sub, 0);
        run_one(16'h3C00, 16'h1401);
        check("sticky_expdiff", out_expdiff, 10);
        check("sticky_man_s", out_man_s, 14'h009);
        check("sticky_sign_l", out_sign_l, 0);
        run_one(16'h7C00, 16'hFC00);
        check("infinf_special", out_special, 1);
        check("infinf_val", out_special_val, 16'h7E00);
        run_one(16'h8000, 16'h8000);
        check("negzero_val", out_special_val, 16'h8000);
        run_one(16'h7E01, 16'h3C00);
        check("nan_val", out_special_val, 16'h7E00);
        run_one(16'h0001, 16'h3C00);
        check("sub_expdiff", out_expdiff, 14);
`ifdef FP16_FE_FTZ_EN
        check("sub_man_s_ftz", out_man_s, 14'h000);
`else
        check("sub_man_s", out_man_s, 14'h001);
`endif
        run_one(16'hBC00, 16'h3C00);
        check("tie_sign_l", out_sign_l, 1);
        check("tie_sub", out_sub, 1);
        step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);

        // Backpressure: six offers, five accepted.
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 16'h3C00 + 16'(i), 16'h3800 + 16'(i * 3), 1'b0);
            if (last_rdy) acc++;
        end
        check("bp_accepted", acc, 5);
        check("bp_in_ready", in_ready, 0);
        check("bp_count", fifo_count, 4);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);

        // Reset with three pairs buffered behind a held output.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'h4000 + 16'(i), 16'h3C00, 1'b0);
        check("mid_count_pre", fifo_count, 3);
        step(1'b0, 1'b1, 16'h4400, 16'h3C00, 1'b0);
        check("mid_valid", out_valid, 0);
        check("mid_count", fifo_count, 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);

        // Randomized traffic with random stalls.
        for (int i = 0; i < 3000; i++) begin
            step(1'b1, $urandom_range(0, 3) != 0, gen_op(), gen_op(),
                 $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < DEPTH + 3; i++) step(1'b1, 1'b0, 16'h0, 16'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
